operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are listed clock and reset first, as name, direction, width, meaning.
REQ-002 SHALL provide: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide: rst  input  1  synchronous active-high reset.
REQ-004 SHALL provide: sw_in  input  16  operand value from board switches.
REQ-005 SHALL provide: enter  input  1  single-cycle pulse, already debounced upstream.
REQ-006 SHALL provide: op_sel  input  2  operation select: 00 fixed add, 01 fixed mul, 10 float mul, 11 float add.
REQ-007 SHALL provide: num1, num2  output  16 each  registered operands driven to all four operator cores.
REQ-008 SHALL provide: fixA, fixM, floM, floA  input  16 each  combinational core results.
REQ-009 SHALL provide: ovf_in  input  4  core overflow flags, in order [0] fixA, [1] fixM, [2] floM, [3] floA.
REQ-010 SHALL provide: result  output  16  captured selected result.
REQ-011 SHALL provide: overflow  output  1  captured overflow flag of the selected core.
REQ-012 SHALL provide: result_valid  output  1  high while result/overflow hold a valid capture.
REQ-013 SHALL provide: state  output  2  current FSM state, for LEDs.
REQ-014 SHALL provide: op_count  output  8  count of completed captures.

Function
REQ-015 SHALL implement FSM states LOAD1=00, LOAD2=01, COMPUTE=10, SHOW=11, with state output equal to the encoding.
REQ-016 In LOAD1, enter SHALL load num1<=sw_in and move to LOAD2; with no enter, the FSM holds.
REQ-017 In LOAD2, enter SHALL load num2<=sw_in, latch op_sel into an internal op_reg, and move to COMPUTE.
REQ-018 COMPUTE SHALL last exactly one cycle; at its end, result SHALL take the op_reg-selected core output and overflow SHALL take the matching ovf_in bit.
REQ-019 Leaving COMPUTE, the FSM SHALL enter SHOW, set result_valid=1, and increment op_count.
REQ-020 Latency SHALL be: enter in LOAD2 at cycle N -> COMPUTE at N+1 -> result_valid=1 at N+2.
REQ-021 In SHOW, enter SHALL clear result_valid and move to LOAD1; num1, num2, result and overflow SHALL hold their values.
REQ-022 enter during COMPUTE SHALL be ignored, with no queuing.
REQ-023 op_sel changes outside the LOAD2 enter cycle SHALL have no effect on result.
REQ-024 sw_in changes SHALL affect num1/num2 only on the loading enter cycle.
REQ-025 op_count SHALL wrap 255 -> 0 without any flag.
REQ-026 result and overflow SHALL change only on the COMPUTE-exit edge or on reset.
REQ-027 The block SHALL contain no combinational path from the inputs to any output.

Reset
REQ-028 On rst=1 at a clock edge: state=LOAD1, num1=num2=0, result=0, overflow=0, result_valid=0, op_count=0, op_reg=00.
REQ-029 rst SHALL take priority over enter in the same cycle.
REQ-030 rst in any state, including COMPUTE, SHALL abort the operation with no capture and no op_count increment.

Verification
REQ-031 Bench SHALL cover: rst, enter sw_in=16'd27, enter sw_in=16'd42 op_sel=00 -> two cycles later result=16'd69, overflow=0, result_valid=1, op_count=1.
REQ-032 Bench SHALL cover: num1=16'h0100, num2=16'h0200, op_sel=01 -> result=16'h0200 (1.0*2.0 fixed), overflow=0.
REQ-033 Bench SHALL cover: num1=16'h3C00, num2=16'h4000, op_sel=10 -> result=16'h4000 (half-float 1.0*2.0); then changing op_sel to 11 in SHOW leaves result unchanged.
REQ-034 Bench SHALL cover: enter pulsed during COMPUTE -> ignored; state=SHOW next cycle and op_count increments by exactly 1.
REQ-035 Bench SHALL cover: rst asserted in COMPUTE -> next cycle state=00, result_valid=0, result=0, op_count unchanged from 0.
REQ-036 Bench SHALL cover: 256 complete operations from reset -> op_count=0 after the 256th capture.

Source files
------------

// File: rtl/operand_sequencer_if.sv
// Operand sequencer bus: switch/enter inputs, operands out,
// core results in, captured result and status out.
interface operand_sequencer_if;
   logic [15:0] sw_in;
   logic        enter;
   logic [1:0]  op_sel;
   logic [15:0] num1;
   logic [15:0] num2;
   logic [15:0] fixA;
   logic [15:0] fixM;
   logic [15:0] floM;
   logic [15:0] floA;
   logic [3:0]  ovf_in;
   logic [15:0] result;
   logic        overflow;
   logic        result_valid;
   logic [1:0]  state;
   logic [7:0]  op_count;

   modport master (
      output sw_in, enter, op_sel,
      output fixA, fixM, floM, floA, ovf_in,
      input  num1, num2, result, overflow,
      input  result_valid, state, op_count
   );

   modport slave (
      input  sw_in, enter, op_sel,
      input  fixA, fixM, floM, floA, ovf_in,
      output num1, num2, result, overflow,
      output result_valid, state, op_count
   );
endinterface

// File: rtl/operand_sequencer.sv
// Two-operand load/compute/show sequencer feeding four
// operator cores and capturing the selected core result.
module operand_sequencer (
   input  logic               clk,
   input  logic               rst,
   operand_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      LOAD1   = 2'b00,
      LOAD2   = 2'b01,
      COMPUTE = 2'b10,
      SHOW    = 2'b11
   } state_e;

   state_e      state_q;
   logic [15:0] num1_q;
   logic [15:0] num2_q;
   logic [1:0]  op_q;
   logic [15:0] res_q;
   logic        ovf_q;
   logic        valid_q;
   logic [7:0]  cnt_q;

   logic [15:0] res_d;
   logic        ovf_d;

   always_comb begin
      res_d = bus.fixA;
      unique case (op_q)
         2'b00: res_d = bus.fixA;
         2'b01: res_d = bus.fixM;
         2'b10: res_d = bus.floM;
         2'b11: res_d = bus.floA;
      endcase
      ovf_d = bus.ovf_in[op_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD1;
         num1_q  <= '0;
         num2_q  <= '0;
         op_q    <= 2'b00;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            LOAD1: begin
               if (bus.enter) begin
                  num1_q  <= bus.sw_in;
                  state_q <= LOAD2;
               end
            end
            LOAD2: begin
               if (bus.enter) begin
                  num2_q  <= bus.sw_in;
                  op_q    <= bus.op_sel;
                  state_q <= COMPUTE;
               end
            end
            // enter is deliberately not looked at here
            COMPUTE: begin
               res_q   <= res_d;
               ovf_q   <= ovf_d;
               valid_q <= 1'b1;
               cnt_q   <= cnt_q + 8'd1;
               state_q <= SHOW;
            end
            SHOW: begin
               if (bus.enter) begin
                  valid_q <= 1'b0;
                  state_q <= LOAD1;
               end
            end
         endcase
      end
   end

   assign bus.num1         = num1_q;
   assign bus.num2         = num2_q;
   assign bus.result       = res_q;
   assign bus.overflow     = ovf_q;
   assign bus.result_valid = valid_q;
   assign bus.state        = state_q;
   assign bus.op_count     = cnt_q;
endmodule

// File: tb/tb_operand_sequencer.sv
// Directed and randomized checks of operand_sequencer
// against behavioural operator cores and a simple model.
module tb_operand_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cnt_m = 0;

   operand_sequencer_if ifc ();

   operand_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] hmul(
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic [21:0] p;
      int          e;
      logic [9:0]  m;
      p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
      e = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (p[21]) begin
         m = p[20:11];
         e = e + 1;
      end else begin
         m = p[19:10];
      end
      return {a[15] ^ b[15], e[4:0], m};
   endfunction

   function automatic logic [15:0] core(
      input logic [1:0]  op,
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic [31:0] pr;
      pr = a * b;
      case (op)
         2'd0: return a + b;
         2'd1: return pr[23:8];
         2'd2: return hmul(a, b);
         default: return a - b;
      endcase
   endfunction

   // behavioural operator cores driven from the operand regs
   always_comb begin
      ifc.fixA = core(2'd0, ifc.num1, ifc.num2);
      ifc.fixM = core(2'd1, ifc.num1, ifc.num2);
      ifc.floM = core(2'd2, ifc.num1, ifc.num2);
      ifc.floA = core(2'd3, ifc.num1, ifc.num2);
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(
      input logic [15:0] sw,
      input logic [1:0]  op
   );
      ifc.sw_in  = sw;
      ifc.op_sel = op;
      ifc.enter  = 1'b1;
      tick();
      ifc.enter  = 1'b0;
      ifc.sw_in  = 16'($urandom);
      ifc.op_sel = 2'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cnt_m = 0;
   endtask

   task automatic do_op(
      input logic [15:0] a,
      input logic [15:0] b,
      input logic [1:0]  op,
      input logic [3:0]  ov
   );
      logic [15:0] er;
      er = core(op, a, b);
      ifc.ovf_in = ov;
      pulse(a, op);
      chk("l1_state", ifc.state, 2'd1);
      chk("num1", ifc.num1, a);
      pulse(b, op);
      chk("l2_state", ifc.state, 2'd2);
      chk("num2", ifc.num2, b);
      chk("cmp_valid", ifc.result_valid, 1'b0);
      tick();
      cnt_m = (cnt_m + 1) % 256;
      chk("show_state", ifc.state, 2'd3);
      chk("valid", ifc.result_valid, 1'b1);
      chk("result", ifc.result, er);
      chk("overflow", ifc.overflow, ov[op]);
      chk("op_count", ifc.op_count, cnt_m[7:0]);
   endtask

   task automatic leave_show(
      input logic [15:0] er
   );
      ifc.ovf_in = 4'($urandom);
      pulse(16'($urandom), 2'($urandom));
      chk("exit_state", ifc.state, 2'd0);
      chk("exit_valid", ifc.result_valid, 1'b0);
      chk("exit_hold", ifc.result, er);
   endtask

   initial begin
      ifc.sw_in  = 16'hFFFF;
      ifc.enter  = 1'b0;
      ifc.op_sel = 2'b11;
      ifc.ovf_in = 4'hF;
      do_reset();
      chk("rst_state", ifc.state, 2'd0);
      chk("rst_num1", ifc.num1, 16'd0);
      chk("rst_num2", ifc.num2, 16'd0);
      chk("rst_result", ifc.result, 16'd0);
      chk("rst_ovf", ifc.overflow, 1'b0);
      chk("rst_valid", ifc.result_valid, 1'b0);
      chk("rst_count", ifc.op_count, 8'd0);

      repeat (3) tick();
      chk("load1_hold", ifc.state, 2'd0);

      do_op(16'd27, 16'd42, 2'b00, 4'b1110);
      chk("add69", ifc.result, 16'd69);
      leave_show(16'd69);
      chk("num1_held", ifc.num1, 16'd27);
      chk("num2_held", ifc.num2, 16'd42);

      do_op(16'h0100, 16'h0200, 2'b01, 4'b1101);
      chk("fixmul", ifc.result, 16'h0200);
      leave_show(16'h0200);

      do_op(16'h3C00, 16'h4000, 2'b10, 4'b1011);
      chk("flomul", ifc.result, 16'h4000);
      ifc.op_sel = 2'b11;
      ifc.sw_in  = 16'h1234;
      ifc.ovf_in = 4'hF;
      repeat (3) tick();
      chk("sel_late", ifc.result, 16'h4000);
      chk("ovf_late", ifc.overflow, 1'b0);
      chk("show_hold", ifc.state, 2'd3);
      chk("sw_late", ifc.num1, 16'h3C00);
      leave_show(16'h4000);

      ifc.ovf_in = 4'h0;
      pulse(16'd5, 2'b00);
      pulse(16'd6, 2'b00);
      chk("c_state", ifc.state, 2'd2);
      ifc.enter = 1'b1;
      tick();
      ifc.enter = 1'b0;
      cnt_m = (cnt_m + 1) % 256;
      chk("c_enter_st", ifc.state, 2'd3);
      chk("c_enter_cnt", ifc.op_count, cnt_m[7:0]);
      chk("c_enter_res", ifc.result, 16'd11);
      tick();
      chk("no_queue_st", ifc.state, 2'd3);
      chk("no_queue_cnt", ifc.op_count, cnt_m[7:0]);
      leave_show(16'd11);

      pulse(16'd9, 2'b00);
      rst = 1'b1;
      ifc.enter = 1'b1;
      ifc.sw_in = 16'd77;
      tick();
      rst = 1'b0;
      ifc.enter = 1'b0;
      cnt_m = 0;
      chk("rst_pri_st", ifc.state, 2'd0);
      chk("rst_pri_num1", ifc.num1, 16'd0);
      chk("rst_pri_cnt", ifc.op_count, 8'd0);

      ifc.ovf_in = 4'hF;
      pulse(16'd100, 2'b00);
      pulse(16'd200, 2'b00);
      chk("abort_pre", ifc.state, 2'd2);
      do_reset();
      chk("abort_state", ifc.state, 2'd0);
      chk("abort_valid", ifc.result_valid, 1'b0);
      chk("abort_result", ifc.result, 16'd0);
      chk("abort_ovf", ifc.overflow, 1'b0);
      chk("abort_count", ifc.op_count, 8'd0);
      tick();
      chk("abort_after", ifc.state, 2'd0);
      chk("abort_cnt2", ifc.op_count, 8'd0);

      for (int i = 0; i < 256; i++) begin
         logic [15:0] a;
         logic [15:0] b;
         logic [1:0]  op;
         a  = 16'($urandom);
         b  = 16'($urandom);
         op = 2'($urandom);
         do_op(a, b, op, 4'($urandom));
         leave_show(core(op, a, b));
      end
      chk("wrap_count", ifc.op_count, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
